// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

  localparam int         CMD_WR_BIT          = 7;
  localparam int         ADDR_W              = 7;
  localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_FETCH,
    ST_RD_LOAD,
    ST_RD_WAIT
  } cmd_state_t;

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select with edge pulses.
// o_Valid marks the point where the synced value reflects a real sample, not the reset value.
module cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Valid
);

  logic [2:0] r_shift;
  logic [1:0] r_vld;

  // NOTE: the chain resets to 1 (CS idle level) so reset release never fabricates a CS edge on its own.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_shift <= '1;
      r_vld   <= '0;
    end else begin
      r_shift <= {r_shift[1:0], i_Async};
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

  assign o_Sync  = r_shift[1];
  assign o_Rise  = r_shift[1] & ~r_shift[2];
  assign o_Fall  = ~r_shift[1] & r_shift[2];
  assign o_Valid = r_vld[1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns SPI_Slave byte traffic into register-file write/read strobes with auto-incrementing
// address, and feeds read data back to the slave one byte ahead of MISO.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_Wr_En,
  output logic [7:0]        o_Reg_Wr_Data,
  output logic              o_Reg_Rd_En,
  input  logic [7:0]        i_Reg_Rd_Data,
  output logic              o_Busy,
  output logic              o_Frame_Abort
);

  logic w_cs_sync, w_cs_rise, w_cs_fall, w_cs_valid;

  cs_sync u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_SPI_CS_n),
    .o_Sync  (w_cs_sync),
    .o_Rise  (w_cs_rise),
    .o_Fall  (w_cs_fall),
    .o_Valid (w_cs_valid)
  );

  cmd_state_t        r_state;
  logic              r_armed, r_data_seen, r_busy, r_abort;
  logic              r_tx_dv, r_wr_en, r_rd_en;
  logic [7:0]        r_tx_byte, r_wr_data;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_data_seen <= 1'b0;
      r_busy      <= 1'b0;
      r_abort     <= 1'b0;
      r_tx_dv     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_tx_byte   <= '0;
      r_wr_data   <= '0;
      r_addr      <= '0;
    end else begin
      // NOTE: strobes default low every cycle, so no path can hold one high for two cycles.
      r_tx_dv <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_abort <= 1'b0;

      if (w_cs_valid && w_cs_sync)
        r_armed <= 1'b1;

      // Write address advances the cycle after the strobe so o_Reg_Addr is stable during it.
      if (r_wr_en && AUTO_INC)
        r_addr <= r_addr + ADDR_W'(1);

      if (r_state != ST_IDLE && w_cs_rise) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        if (r_state == ST_CMD || (r_state == ST_RD_WAIT && !r_data_seen))
          r_abort <= 1'b1;
        if (r_state == ST_WR_DATA) begin
          if (i_RX_DV) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= i_RX_Byte;
          end else if (!r_data_seen) begin
            r_abort <= 1'b1;
          end
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_tx_dv     <= 1'b1;
              r_tx_byte   <= STATUS_BYTE;
              r_busy      <= 1'b1;
              r_data_seen <= 1'b0;
              r_state     <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (i_RX_DV) begin
              r_addr <= i_RX_Byte[ADDR_W-1:0];
              if (i_RX_Byte[CMD_WR_BIT]) begin
                r_state <= ST_WR_DATA;
              end else begin
                r_rd_en <= 1'b1;
                r_state <= ST_RD_FETCH;
              end
            end
          end
          ST_WR_DATA: begin
            if (i_RX_DV) begin
              r_wr_en     <= 1'b1;
              r_wr_data   <= i_RX_Byte;
              r_data_seen <= 1'b1;
            end
          end
          ST_RD_FETCH: r_state <= ST_RD_LOAD;
          ST_RD_LOAD: begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= i_Reg_Rd_Data;
            r_state   <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            if (i_RX_DV) begin
              r_data_seen <= 1'b1;
              if (AUTO_INC)
                r_addr <= r_addr + ADDR_W'(1);
              r_rd_en <= 1'b1;
              r_state <= ST_RD_FETCH;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_TX_DV       = r_tx_dv;
  assign o_TX_Byte     = r_tx_byte;
  assign o_Reg_Addr    = r_addr;
  assign o_Reg_Wr_En   = r_wr_en;
  assign o_Reg_Wr_Data = r_wr_data;
  assign o_Reg_Rd_En   = r_rd_en;
  assign o_Busy        = r_busy;
  assign o_Frame_Abort = r_abort;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: expectations queued at stimulus time, popped by output monitors.
module tb_spi_cmd_decoder;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    logic       lat_chk;
  } tx_t;

  logic       clk, rst, cs_n, rx_dv, use_b, rx_dv_b;
  logic [7:0] rx_byte, rd_data;
  logic       tx_dv, wr_en, rd_en, busy, abort;
  logic [7:0] tx_byte, wr_data;
  logic [6:0] addr;
  logic       tx_dv_b, wr_en_b, rd_en_b, busy_b, abort_b;
  logic [7:0] tx_byte_b, wr_data_b;
  logic [6:0] addr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_abort  = 0;
  int cyc      = 0;
  int last_rx  = 0;
  int ab0;

  wr_t        exp_wr[$];
  wr_t        exp_wr_b[$];
  logic [6:0] exp_rd[$];
  tx_t        exp_tx[$];
  wr_t        e_wr, e_wr_b;
  tx_t        e_tx;
  logic [6:0] e_rd;

  assign rx_dv_b = rx_dv & use_b;

  spi_cmd_decoder #(.STATUS_BYTE(8'hA5), .AUTO_INC(1'b1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_CS_n(cs_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_Reg_Addr(addr), .o_Reg_Wr_En(wr_en),
    .o_Reg_Wr_Data(wr_data), .o_Reg_Rd_En(rd_en), .i_Reg_Rd_Data(rd_data),
    .o_Busy(busy), .o_Frame_Abort(abort)
  );

  spi_cmd_decoder #(.STATUS_BYTE(8'hA5), .AUTO_INC(1'b0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_CS_n(cs_n), .i_RX_DV(rx_dv_b), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv_b), .o_TX_Byte(tx_byte_b), .o_Reg_Addr(addr_b), .o_Reg_Wr_En(wr_en_b),
    .o_Reg_Wr_Data(wr_data_b), .o_Reg_Rd_En(rd_en_b), .i_Reg_Rd_Data(8'h00),
    .o_Busy(busy_b), .o_Frame_Abort(abort_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: registered read returning addr ^ 8'hFF one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= {1'b0, addr} ^ 8'hFF;
    cyc <= cyc + 1;
    if (rx_dv) last_rx <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_present(input string tag, input int size, input logic [31:0] obs);
    n_checks++;
    assert (size != 0) else begin
      n_fail++;
      $error("FAIL %s: observed unexpected event %0h expected none", tag, obs);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (abort) n_abort++;
      if (wr_en) begin
        expect_present("wr_unexpected", exp_wr.size(), {addr, wr_data});
        if (exp_wr.size() != 0) begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", addr, e_wr.addr);
          check("wr_data", wr_data, e_wr.data);
        end
      end
      if (wr_en_b) begin
        expect_present("wr_b_unexpected", exp_wr_b.size(), {addr_b, wr_data_b});
        if (exp_wr_b.size() != 0) begin
          e_wr_b = exp_wr_b.pop_front();
          check("wr_b_addr", addr_b, e_wr_b.addr);
          check("wr_b_data", wr_data_b, e_wr_b.data);
        end
      end
      if (rd_en) begin
        expect_present("rd_unexpected", exp_rd.size(), addr);
        if (exp_rd.size() != 0) begin
          e_rd = exp_rd.pop_front();
          check("rd_addr", addr, e_rd);
        end
      end
      if (tx_dv) begin
        expect_present("tx_unexpected", exp_tx.size(), tx_byte);
        if (exp_tx.size() != 0) begin
          e_tx = exp_tx.pop_front();
          check("tx_byte", tx_byte, e_tx.data);
          if (e_tx.lat_chk) check("tx_latency", cyc - last_rx, 2);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk) cs_n = 1'b0;
    idle(8);
  endtask

  task automatic cs_high();
    @(negedge clk) cs_n = 1'b1;
    idle(8);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk) begin rx_dv = 1'b1; rx_byte = b; end
    @(negedge clk) rx_dv = 1'b0;
    idle(8);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tx_dv"}, tx_dv, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_abort"}, abort, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wr_q"}, exp_wr.size(), 0);
    check({tag, "_rd_q"}, exp_rd.size(), 0);
    check({tag, "_tx_q"}, exp_tx.size(), 0);
    check({tag, "_wr_b_q"}, exp_wr_b.size(), 0);
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; use_b = 1'b0;
    idle(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(6);

    // Write burst
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_wr.push_back('{7'h05, 8'h11});
    exp_wr.push_back('{7'h06, 8'h22});
    send(8'h85); send(8'h11); send(8'h22);
    ab0 = n_abort;
    cs_high();
    check("wr_burst_no_abort", n_abort, ab0);
    check_drained("wr_burst");

    // Read burst
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_rd.push_back(7'h10); exp_rd.push_back(7'h11); exp_rd.push_back(7'h12);
    exp_tx.push_back('{8'hEF, 1'b1});
    exp_tx.push_back('{8'hEE, 1'b1});
    exp_tx.push_back('{8'hED, 1'b1});
    send(8'h10); send(8'h00); send(8'h00);
    ab0 = n_abort;
    cs_high();
    check("rd_burst_no_abort", n_abort, ab0);
    check_drained("rd_burst");

    // Address wrap, both increment modes
    use_b = 1'b1;
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_wr.push_back('{7'h7F, 8'h01});
    exp_wr.push_back('{7'h00, 8'h02});
    exp_wr_b.push_back('{7'h7F, 8'h01});
    exp_wr_b.push_back('{7'h7F, 8'h02});
    send(8'hFF); send(8'h01); send(8'h02);
    cs_high();
    use_b = 1'b0;
    check_drained("wrap");

    // Abort after a read command: prefetch still happens, then CS rises before any data byte
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_rd.push_back(7'h03);
    exp_tx.push_back('{8'hFC, 1'b1});
    send(8'h03);
    ab0 = n_abort;
    @(negedge clk) cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    @(negedge clk);
    check("abort_busy_after", busy, 0);
    check("abort_pulse", abort, 1);
    @(negedge clk);
    check("abort_single_cycle", abort, 0);
    idle(6);
    check("abort_count", n_abort, ab0 + 1);
    check_drained("abort_rd");

    // Abort with no bytes at all (frame ends in CMD)
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    ab0 = n_abort;
    cs_high();
    check("abort_cmd_count", n_abort, ab0 + 1);
    check_drained("abort_cmd");

    // Reset mid-frame with CS held low
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_wr.push_back('{7'h01, 8'h33});
    send(8'h81); send(8'h33);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    idle(6);
    send(8'h44);
    check("midrst_not_busy", busy, 0);
    check("midrst_addr", addr, 0);
    cs_high();
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_wr.push_back('{7'h02, 8'h55});
    send(8'h82); send(8'h55);
    cs_high();
    check_drained("midrst");

    // Last data byte coincident with the synced CS rise
    exp_tx.push_back('{8'hA5, 1'b0});
    cs_low();
    exp_wr.push_back('{7'h10, 8'h01});
    exp_wr.push_back('{7'h11, 8'h02});
    send(8'h90); send(8'h01);
    ab0 = n_abort;
    @(negedge clk) cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk) begin rx_dv = 1'b1; rx_byte = 8'h02; end
    @(negedge clk) rx_dv = 1'b0;
    check("simul_wr_en", wr_en, 1);
    check("simul_busy", busy, 0);
    idle(6);
    check("simul_no_abort", n_abort, ab0);
    check_drained("simul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
